// File: rtl/tmds_align_ctrl.sv
// TMDS word-alignment sequencer: per-channel token-run search, bitslip, loss supervision.
// Ports: clk, reset(async low), pix_locked, sym_i{ch2,ch1,ch0} -> bitslip, aligned, all_aligned, rot_err.
module tmds_align_ctrl #(
  parameter int TOKEN_RUN  = 8,
  parameter int SEARCH_LEN = 4096,
  parameter int SLIP_WAIT  = 16,
  parameter int LOSS_LEN   = 65536,
  parameter int MAX_SLIPS  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_locked,
  input  logic [29:0] sym_i,
  output logic [2:0]  bitslip,
  output logic [2:0]  aligned,
  output logic        all_aligned,
  output logic [2:0]  rot_err
);

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int RW = cw(TOKEN_RUN + 1);
  localparam int WW = cw(SEARCH_LEN);
  localparam int SW = cw(SLIP_WAIT);
  localparam int LW = cw(LOSS_LEN);
  localparam int IW = cw(MAX_SLIPS);

  typedef enum logic [2:0] {
    S_IDLE, S_SEARCH, S_SLIP, S_SETTLE, S_ALIGNED
  } state_t;

  function automatic logic is_tok(input logic [9:0] s);
    return (s == 10'b1101010100) || (s == 10'b0010101011) ||
           (s == 10'b0101010100) || (s == 10'b1010101011);
  endfunction

  logic r_all;

  for (genvar g = 0; g < 3; g++) begin : g_ch
    state_t        r_state, w_next;
    logic [RW-1:0] r_run, w_run, w_run_nx;
    logic [WW-1:0] r_win, w_win;
    logic [SW-1:0] r_set, w_set;
    logic [LW-1:0] r_loss, w_loss;
    logic [IW-1:0] r_idx, w_idx;
    logic          r_rot, w_rot;
    logic          r_bs, r_al;
    logic          w_tok, w_done;

    assign w_tok = is_tok(sym_i[10*g +: 10]);
    // Run counter saturates so long blanking runs keep counting as complete.
    assign w_run_nx = !w_tok ? '0 :
                      (r_run == RW'(TOKEN_RUN)) ? r_run :
                      r_run + RW'(1);
    assign w_done = w_tok && (r_run >= RW'(TOKEN_RUN - 1));

    always_comb begin
      w_next = r_state;
      w_run  = r_run;
      w_win  = r_win;
      w_set  = r_set;
      w_loss = r_loss;
      w_idx  = r_idx;
      w_rot  = r_rot;
      if (!pix_locked) begin
        w_next = S_IDLE;
        w_run  = '0;
        w_win  = '0;
        w_set  = '0;
        w_loss = '0;
        w_idx  = '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            w_next = S_SEARCH;
            w_run  = '0;
            w_win  = '0;
          end
          S_SEARCH: begin
            w_run = w_run_nx;
            if (w_done) begin
              w_next = S_ALIGNED;
              w_loss = '0;
              w_win  = '0;
            end else if (r_win == WW'(SEARCH_LEN - 1)) begin
              w_next = S_SLIP;
              w_run  = '0;
              w_win  = '0;
            end else begin
              w_win = r_win + WW'(1);
            end
          end
          S_SLIP: begin
            w_next = S_SETTLE;
            w_set  = '0;
            if (r_idx == IW'(MAX_SLIPS - 1)) begin
              w_idx = '0;
              w_rot = 1'b1;
            end else begin
              w_idx = r_idx + IW'(1);
            end
          end
          S_SETTLE: begin
            w_run = '0;
            if (r_set == SW'(SLIP_WAIT - 1)) begin
              w_next = S_SEARCH;
              w_win  = '0;
              w_set  = '0;
            end else begin
              w_set = r_set + SW'(1);
            end
          end
          S_ALIGNED: begin
            w_run = w_run_nx;
            if (w_done) begin
              w_loss = '0;
            end else if (r_loss == LW'(LOSS_LEN - 1)) begin
              w_next = S_SEARCH;
              w_win  = '0;
              w_loss = '0;
            end else begin
              w_loss = r_loss + LW'(1);
            end
          end
          default: w_next = S_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state <= S_IDLE;
        r_run   <= '0;
        r_win   <= '0;
        r_set   <= '0;
        r_loss  <= '0;
        r_idx   <= '0;
        r_rot   <= 1'b0;
        r_bs    <= 1'b0;
        r_al    <= 1'b0;
      end else begin
        r_state <= w_next;
        r_run   <= w_run;
        r_win   <= w_win;
        r_set   <= w_set;
        r_loss  <= w_loss;
        r_idx   <= w_idx;
        r_rot   <= w_rot;
        r_bs    <= (w_next == S_SLIP);
        r_al    <= (w_next == S_ALIGNED);
      end
    end

    assign bitslip[g] = r_bs;
    assign aligned[g] = r_al;
    assign rot_err[g] = r_rot;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_all <= 1'b0;
    else        r_all <= &aligned;
  end

  assign all_aligned = r_all;

endmodule

// File: tb/tb_tmds_align_ctrl.sv
// Bench for tmds_align_ctrl: deserializer rotation model, behavioural reference, directed scenarios.
// Drives sym_i from per-channel word sources rotated by a slip-driven bit offset.
module tb_tmds_align_ctrl;
  localparam int TR = 8, SL = 64, SWT = 4, LL = 256, MS = 10;
  localparam int M_IDLE = 0, M_SRCH = 1, M_SLP = 2, M_SET = 3, M_ALGN = 4;
  localparam logic [9:0] TOK = 10'b1101010100;
  localparam logic [9:0] DAT = 10'h155;

  logic clk = 1'b0;
  logic reset, pix_locked;
  logic [29:0] sym_i;
  logic [2:0] bitslip, aligned, rot_err;
  logic all_aligned;

  int wmode[3], rot[3];
  int sidx = 0, cyc = 0;
  int n_chk = 0, n_fail = 0;

  int m_mode[3], m_streak[3], m_t[3], m_quiet[3], m_slips[3];
  logic [2:0] m_bs = '0, m_al = '0, m_re = '0;
  logic m_all = 1'b0;

  int bs_q[3][$];
  int al_rise[3], al_fall[3], re_rise[3];
  int all_rise, all_fall;
  logic [2:0] pa = '0, pre = '0;
  logic pall = 1'b0;
  int t0, t1, t2;

  tmds_align_ctrl #(
    .TOKEN_RUN(TR), .SEARCH_LEN(SL), .SLIP_WAIT(SWT),
    .LOSS_LEN(LL), .MAX_SLIPS(MS)
  ) dut (
    .clk(clk), .reset(reset), .pix_locked(pix_locked),
    .sym_i(sym_i), .bitslip(bitslip), .aligned(aligned),
    .all_aligned(all_aligned), .rot_err(rot_err)
  );

  always #5 clk = ~clk;

  function automatic logic tb_tok(input logic [9:0] s);
    logic [9:0] t[4];
    t[0] = 10'b1101010100; t[1] = 10'b0010101011;
    t[2] = 10'b0101010100; t[3] = 10'b1010101011;
    for (int i = 0; i < 4; i++) if (s == t[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] w, input int r);
    logic [19:0] d;
    d = {w, w} << r;
    return d[19:10];
  endfunction

  function automatic logic [9:0] word_of(input int md, input int k);
    if (md == 0) return TOK;
    if (md == 1) return DAT;
    return ((k % 8) != 7) ? TOK : DAT;
  endfunction

  always_comb begin
    sym_i = '0;
    for (int c = 0; c < 3; c++)
      sym_i[c*10 +: 10] = rotl(word_of(wmode[c], sidx), rot[c]);
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference: elapsed-time view of each channel.
  initial begin
    for (int c = 0; c < 3; c++) begin
      m_mode[c] = M_IDLE; m_streak[c] = 0; m_t[c] = 0;
      m_quiet[c] = 0; m_slips[c] = 0;
    end
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        for (int c = 0; c < 3; c++) begin
          m_mode[c] = M_IDLE; m_streak[c] = 0; m_t[c] = 0;
          m_quiet[c] = 0; m_slips[c] = 0;
        end
        m_bs = '0; m_al = '0; m_re = '0; m_all = 1'b0;
      end else begin
        m_all = &m_al;
        for (int c = 0; c < 3; c++) begin
          logic tk;
          tk = tb_tok(sym_i[c*10 +: 10]);
          if (!pix_locked) begin
            m_mode[c] = M_IDLE; m_streak[c] = 0; m_t[c] = 0;
            m_quiet[c] = 0; m_slips[c] = 0;
          end else begin
            case (m_mode[c])
              M_IDLE: begin
                m_mode[c] = M_SRCH; m_t[c] = 0; m_streak[c] = 0;
              end
              M_SRCH: begin
                m_streak[c] = tk ? m_streak[c] + 1 : 0;
                m_t[c]++;
                if (m_streak[c] >= TR) begin
                  m_mode[c] = M_ALGN; m_quiet[c] = 0;
                end else if (m_t[c] == SL) begin
                  m_mode[c] = M_SLP; m_streak[c] = 0;
                end
              end
              M_SLP: begin
                m_slips[c]++;
                if (m_slips[c] == MS) begin
                  m_slips[c] = 0; m_re[c] = 1'b1;
                end
                m_mode[c] = M_SET; m_t[c] = 0;
              end
              M_SET: begin
                m_streak[c] = 0;
                m_t[c]++;
                if (m_t[c] == SWT) begin
                  m_mode[c] = M_SRCH; m_t[c] = 0;
                end
              end
              default: begin
                m_streak[c] = tk ? m_streak[c] + 1 : 0;
                if (m_streak[c] >= TR) m_quiet[c] = 0;
                else begin
                  m_quiet[c]++;
                  if (m_quiet[c] == LL) begin
                    m_mode[c] = M_SRCH; m_t[c] = 0;
                  end
                end
              end
            endcase
          end
          m_bs[c] = (m_mode[c] == M_SLP);
          m_al[c] = (m_mode[c] == M_ALGN);
        end
      end
    end
  end

  // Per-cycle compare, event log and deserializer slip response.
  initial forever begin
    @(negedge clk);
    chk("outputs{bs,al,all,re}",
        int'({bitslip, aligned, all_aligned, rot_err}),
        int'({m_bs, m_al, m_all, m_re}));
    for (int c = 0; c < 3; c++) begin
      if (bitslip[c]) begin
        bs_q[c].push_back(cyc);
        rot[c] = (rot[c] + 9) % 10;
      end
      if (aligned[c] && !pa[c]) al_rise[c] = cyc;
      if (!aligned[c] && pa[c]) al_fall[c] = cyc;
      if (rot_err[c] && !pre[c]) re_rise[c] = cyc;
    end
    if (all_aligned && !pall) all_rise = cyc;
    if (!all_aligned && pall) all_fall = cyc;
    pa = aligned; pre = rot_err; pall = all_aligned;
    sidx++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    for (int c = 0; c < 3; c++) begin
      bs_q[c].delete();
      al_rise[c] = -1; al_fall[c] = -1; re_rise[c] = -1;
    end
    all_rise = -1; all_fall = -1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pix_locked = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rot[c] = 0; wmode[c] = 0;
    end
    step();
    clear_log();
  endtask

  initial begin
    reset = 1'b1;
    pix_locked = 1'b0;
    for (int c = 0; c < 3; c++) begin
      wmode[c] = 0; rot[c] = 0;
    end
    clear_log();
    #1 reset = 1'b0;

    // 1: clean lock on all channels
    do_reset();
    chk("reset outputs", int'({bitslip, aligned, all_aligned, rot_err}), 0);
    pix_locked = 1'b1; t0 = cyc;
    repeat (20) step();
    for (int c = 0; c < 3; c++) chk("s1 align delay", al_rise[c] - t0, 9);
    chk("s1 all_aligned delay", all_rise - t0, 10);
    chk("s1 no slips", bs_q[0].size() + bs_q[1].size() + bs_q[2].size(), 0);

    // 2: ch1 rotated by 3 bits
    do_reset();
    rot[1] = 3;
    pix_locked = 1'b1; t0 = cyc;
    repeat (300) step();
    chk("s2 ch1 slips", bs_q[1].size(), 3);
    chk("s2 first slip", bs_q[1].size() >= 1 ? bs_q[1][0] - t0 : -1, 65);
    chk("s2 gap1", bs_q[1].size() >= 2 ? bs_q[1][1] - bs_q[1][0] : -1, 69);
    chk("s2 gap2", bs_q[1].size() >= 3 ? bs_q[1][2] - bs_q[1][1] : -1, 69);
    chk("s2 ch1 align time", al_rise[1] - t0, 216);
    chk("s2 other slips", bs_q[0].size() + bs_q[2].size(), 0);
    chk("s2 aligned", int'(aligned), 7);
    chk("s2 rot_err", int'(rot_err), 0);

    // 3: ch2 data only -> full rotation
    do_reset();
    wmode[2] = 1;
    pix_locked = 1'b1; t0 = cyc;
    repeat (700) step();
    chk("s3 ch2 slips", bs_q[2].size(), 10);
    chk("s3 rot_err rise", re_rise[2] - t0, 687);
    chk("s3 rot_err", int'(rot_err), 4);
    wmode[2] = 0;
    repeat (200) step();
    chk("s3 relock aligned", int'(aligned), 7);
    chk("s3 rot_err sticky", int'(rot_err), 4);

    // 4: ch0 loses tokens
    wmode[0] = 1; t1 = cyc;
    repeat (300) step();
    chk("s4 ch0 fall", al_fall[0] - t1, 256);
    chk("s4 all fall", all_fall - t1, 257);
    chk("s4 ch1/ch2 held", int'(aligned[2:1]), 3);

    // 5: runs of 7 tokens never lock
    do_reset();
    for (int c = 0; c < 3; c++) wmode[c] = 2;
    pix_locked = 1'b1; t0 = cyc;
    repeat (300) step();
    chk("s5 aligned", int'(aligned), 0);
    for (int c = 0; c < 3; c++) chk("s5 slips", bs_q[c].size(), 4);
    chk("s5 first slip", bs_q[0].size() >= 1 ? bs_q[0][0] - t0 : -1, 65);
    chk("s5 gap", bs_q[0].size() >= 2 ? bs_q[0][1] - bs_q[0][0] : -1, 69);

    // 6a: pix_locked dropped in SETTLE
    do_reset();
    for (int c = 0; c < 3; c++) wmode[c] = 1;
    pix_locked = 1'b1; t0 = cyc;
    repeat (67) step();
    chk("s6a slip seen", bs_q[0].size(), 1);
    pix_locked = 1'b0;
    step();
    chk("s6a bitslip", int'(bitslip), 0);
    chk("s6a aligned", int'(aligned), 0);
    repeat (3) step();
    clear_log();
    pix_locked = 1'b1; t2 = cyc;
    repeat (66) step();
    chk("s6a resume slips", bs_q[0].size(), 1);
    chk("s6a resume window", bs_q[0].size() >= 1 ? bs_q[0][0] - t2 : -1, 65);

    // 6b: reset during SLIP
    do_reset();
    for (int c = 0; c < 3; c++) wmode[c] = 1;
    pix_locked = 1'b1; t0 = cyc;
    repeat (65) step();
    chk("s6b in slip", int'(bitslip), 7);
    reset = 1'b0;
    #1;
    chk("s6b async clear",
        int'({bitslip, aligned, all_aligned, rot_err}), 0);
    step();
    reset = 1'b1;
    clear_log();
    t2 = cyc;
    repeat (66) step();
    chk("s6b resume window", bs_q[1].size() >= 1 ? bs_q[1][0] - t2 : -1, 65);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
